agu_context_store: RTL and testbench
====================================

Name: agu_context_store

Overview:
- Parametrised context memory for the AGU datapath, successor to the single-port AGU context cache.
- During configuration, context words are streamed in sequentially with a valid/ready handshake.
- At run time, NCH independent channels each read a word addressed by their own context pointer.
- Adds occupancy tracking, full back-pressure, a clear, out-of-range pointer detection and registered reads with a valid strobe.

Parameters:
- WIDTH, 29, context word width in bits.
- DEPTH, 64, number of context entries; must be at most 2**AW.
- AW, 6, address and pointer width.
- NCH, 2, number of independent read channels.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- start  input  1  0 = configuration (load) mode, 1 = run mode.
- clear  input  1  synchronous: empties the store (count to 0).
- ld_valid  input  1  load word present.
- ld_data  input  WIDTH  load word.
- ld_ready  output  1  store can accept a load word this cycle.
- count  output  AW+1  number of valid entries, 0..DEPTH.
- full  output  1  count == DEPTH.
- rd_en  input  NCH  per-channel read request.
- CP  input  NCH*AW  per-channel context pointer; channel i uses bits [i*AW +: AW].
- rd_data  output  NCH*WIDTH  registered read data; channel i uses [i*WIDTH +: WIDTH].
- rd_valid  output  NCH  per-channel read data valid strobe.
- rd_err  output  NCH  per-channel flag: the pointer was out of range.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state = LOAD, count = 0.
  - rd_data = 0, rd_valid = 0, rd_err = 0.
  - Memory contents are not reset.
- States:
  - LOAD: start = 0 and count < DEPTH.
  - FULL: start = 0 and count == DEPTH.
  - RUN: start = 1.
- Transitions, evaluated every cycle:
  - clear has the highest priority: count goes to 0 and the next state is LOAD if start = 0, otherwise RUN.
  - LOAD to FULL: when an accepted write brings count to DEPTH.
  - LOAD or FULL to RUN: when start = 1.
  - RUN to LOAD or FULL: when start = 0. count is retained, so subsequent loads append.
- Load path:
  - ld_ready = (state == LOAD) and not clear.
  - A write is accepted when ld_valid and ld_ready are both high: mem[count] gets ld_data and count increments.
  - When full, ld_valid is ignored and no write or wrap-around occurs; count saturates at DEPTH.
  - clear and ld_valid in the same cycle: the word is dropped and count goes to 0.
- Read path (any state; normally used in RUN):
  - A read on channel i is issued when rd_en[i] is high.
  - One cycle later: rd_valid[i] = 1 and rd_data[i] = mem[CP_i].
  - Out of range (CP_i >= count):
    - rd_err[i] = 1 and rd_data[i] = 0 in that same result cycle.
    - rd_valid[i] still pulses.
  - Cycles with rd_en[i] low:
    - rd_valid[i] = 0 and rd_err[i] = 0.
    - rd_data[i] holds its previous value.
  - Channels are fully independent; equal pointers on several channels are legal.
- Read and load of the same address in the same cycle:
  - Not possible without the option, because reads are meant for RUN.
  - If it does occur in LOAD, the read returns the old contents and rd_err is evaluated against the pre-increment count.
- Reset asserted mid-operation:
  - Any pending read result is discarded.
  - rd_valid goes to 0 immediately (asynchronously).

Optional Feature:
- Macro AGU_CTX_RELOAD_EN.
- Defined:
  - Adds inputs rl_valid (1 bit), rl_addr (AW bits) and rl_data (WIDTH bits).
  - In RUN, rl_valid overwrites mem[rl_addr] when rl_addr < count; otherwise the write is ignored. count is unchanged.
  - A same-cycle read of rl_addr forwards rl_data; the new value appears at rd_data one cycle later.
- Undefined:
  - No such ports exist.
  - Memory is writable only through the load path.

Test Plan:
- Reset, then load 64 words 0x100+i with ld_valid held -> count = 64, full = 1, ld_ready = 0; a 65th word is ignored and count stays 64.
- Load 3 words, start = 1, CP0 = 2 and CP1 = 0 with rd_en = 2'b11 -> next cycle rd_valid = 2'b11, rd_data0 = 0x102, rd_data1 = 0x100, rd_err = 0.
- With count = 3, CP0 = 5 and rd_en0 = 1 -> rd_valid0 = 1, rd_err0 = 1, rd_data0 = 0.
- clear asserted together with ld_valid while count = 10 -> count = 0 the next cycle and the word is not written; a following load writes address 0.
- RST_N pulled low mid-run with rd_en active -> rd_valid = 0 and count = 0 immediately; after release, ld_ready = 1.
- With AGU_CTX_RELOAD_EN, count = 4 and RUN: rl_addr = 1, rl_data = 0xABC, CP0 = 1 in the same cycle -> rd_data0 = 0xABC; rl_addr = 7 -> ignored.

Source files
------------

// File: rtl/agu_context_store.sv
// agu_context_store: sequentially loaded context memory with NCH registered read channels.
// Optional macro AGU_CTX_RELOAD_EN adds a run-time reload port (rl_valid/rl_addr/rl_data).
module agu_context_store #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 64,
    parameter int AW    = 6,
    parameter int NCH   = 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 start,
    input  logic                 clear,
    input  logic                 ld_valid,
    input  logic [WIDTH-1:0]     ld_data,
    output logic                 ld_ready,
    output logic [AW:0]          count,
    output logic                 full,
    input  logic [NCH-1:0]       rd_en,
    input  logic [NCH*AW-1:0]    CP,
    output logic [NCH*WIDTH-1:0] rd_data,
    output logic [NCH-1:0]       rd_valid,
    output logic [NCH-1:0]       rd_err,
    output logic [1:0]           dbg_state
`ifdef AGU_CTX_RELOAD_EN
    ,
    input  logic                 rl_valid,
    input  logic [AW-1:0]        rl_addr,
    input  logic [WIDTH-1:0]     rl_data
`endif
);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FULL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    // Load handshake: a word moves when ld_valid && ld_ready in the same cycle.
    state_e                 state_q, state_d;
    logic [AW:0]            count_q, count_d;
    logic [NCH*WIDTH-1:0]   rd_data_q, rd_data_d;
    logic [NCH-1:0]         rd_valid_q, rd_valid_d;
    logic [NCH-1:0]         rd_err_q, rd_err_d;
    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic                   ld_wr;
    logic                   rl_wr;
    logic [AW-1:0]          rd_ptr;

    // State register plus all resettable datapath flops.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= ST_LOAD;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= '0;
            rd_err_q   <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_err_q   <= rd_err_d;
        end
    end

    // Contents are deliberately not reset.
    always_ff @(posedge CLK) begin
        if (ld_wr) begin
            mem_q[count_q[AW-1:0]] <= ld_data;
        end
`ifdef AGU_CTX_RELOAD_EN
        if (rl_wr) begin
            mem_q[rl_addr] <= rl_data;
        end
`endif
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = start ? ST_RUN : ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (start)                     state_d = ST_RUN;
                    else if (count_d == DEPTH_C)   state_d = ST_FULL;
                end
                ST_FULL: begin
                    if (start)                     state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (!start) state_d = (count_q == DEPTH_C) ? ST_FULL : ST_LOAD;
                end
                default: state_d = ST_LOAD;
            endcase
        end
    end

    // Output logic.
    always_comb begin
        ld_ready  = (state_q == ST_LOAD) && !clear;
        full      = (count_q == DEPTH_C);
        count     = count_q;
        dbg_state = state_q;
        rd_data   = rd_data_q;
        rd_valid  = rd_valid_q;
        rd_err    = rd_err_q;
    end

    // Write enables and occupancy.
    always_comb begin
        ld_wr = ld_valid && ld_ready;
        rl_wr = 1'b0;
`ifdef AGU_CTX_RELOAD_EN
        rl_wr = (state_q == ST_RUN) && rl_valid && ({1'b0, rl_addr} < count_q);
`endif
        count_d = count_q;
        if (clear)      count_d = '0;
        else if (ld_wr) count_d = count_q + 1'b1;
    end

    // Reads compare against the pre-write count and see pre-write memory, except reload forwarding.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en;
        rd_err_d   = '0;
        rd_ptr     = '0;
        for (int i = 0; i < NCH; i++) begin
            rd_ptr = CP[i*AW +: AW];
            if (rd_en[i]) begin
                if ({1'b0, rd_ptr} >= count_q) begin
                    rd_err_d[i]                 = 1'b1;
                    rd_data_d[i*WIDTH +: WIDTH] = '0;
                end else begin
                    rd_data_d[i*WIDTH +: WIDTH] = mem_q[rd_ptr];
`ifdef AGU_CTX_RELOAD_EN
                    if (rl_wr && (rl_addr == rd_ptr)) rd_data_d[i*WIDTH +: WIDTH] = rl_data;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_agu_context_store.sv
// Randomized bench for agu_context_store against an array/counter model of the context store.
// Reload checks are compiled in when AGU_CTX_RELOAD_EN is defined.
module tb_agu_context_store;

    localparam int WIDTH = 29;
    localparam int DEPTH = 64;
    localparam int AW    = 6;
    localparam int NCH   = 2;

    logic                 CLK = 1'b0;
    logic                 RST_N;
    logic                 start, clear, ld_valid;
    logic [WIDTH-1:0]     ld_data;
    logic                 ld_ready;
    logic [AW:0]          count;
    logic                 full;
    logic [NCH-1:0]       rd_en;
    logic [NCH*AW-1:0]    CP;
    logic [NCH*WIDTH-1:0] rd_data;
    logic [NCH-1:0]       rd_valid, rd_err;
    logic [1:0]           dbg_state;
`ifdef AGU_CTX_RELOAD_EN
    logic                 rl_valid;
    logic [AW-1:0]        rl_addr;
    logic [WIDTH-1:0]     rl_data;
`endif

    // clock / reset
    always #5 CLK = ~CLK;

    agu_context_store #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .NCH(NCH)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .clear(clear),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
        .count(count), .full(full), .rd_en(rd_en), .CP(CP),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_err(rd_err),
        .dbg_state(dbg_state)
`ifdef AGU_CTX_RELOAD_EN
        , .rl_valid(rl_valid), .rl_addr(rl_addr), .rl_data(rl_data)
`endif
    );

    // reference model: plain array, occupancy counter, and "mode seen at last edge"
    logic [WIDTH-1:0] mem_m [DEPTH];
    int               count_m;
    bit               run_m;
    logic [WIDTH-1:0] exp_d [NCH];
    bit               exp_v [NCH];
    bit               exp_e [NCH];

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        count_m = 0;
        run_m   = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            exp_d[c] = '0; exp_v[c] = 1'b0; exp_e[c] = 1'b0;
        end
    endtask

    task automatic quiet();
        clear = 1'b0; ld_valid = 1'b0; ld_data = '0; rd_en = '0; CP = '0;
`ifdef AGU_CTX_RELOAD_EN
        rl_valid = 1'b0; rl_addr = '0; rl_data = '0;
`endif
    endtask

    task automatic check_outputs();
        logic [1:0] exp_st;
        exp_st = run_m ? 2'd2 : ((count_m == DEPTH) ? 2'd1 : 2'd0);
        check("count", 64'(count), 64'(count_m));
        check("full", 64'(full), 64'(count_m == DEPTH));
        check("state", 64'(dbg_state), 64'(exp_st));
        for (int c = 0; c < NCH; c++) begin
            check($sformatf("rd_valid%0d", c), 64'(rd_valid[c]), 64'(exp_v[c]));
            check($sformatf("rd_err%0d", c), 64'(rd_err[c]), 64'(exp_e[c]));
            check($sformatf("rd_data%0d", c), 64'(rd_data[c*WIDTH +: WIDTH]), 64'(exp_d[c]));
        end
    endtask

    // driver: inputs already set; predict the edge, clock once, compare
    task automatic step();
        bit               exp_ready;
        bit               rl_hit;
        int               cp;
        #1;
        exp_ready = !run_m && (count_m < DEPTH) && !clear;
        check("ld_ready", 64'(ld_ready), 64'(exp_ready));
        rl_hit = 1'b0;
`ifdef AGU_CTX_RELOAD_EN
        rl_hit = run_m && rl_valid && (int'(rl_addr) < count_m);
`endif
        for (int c = 0; c < NCH; c++) begin
            exp_v[c] = rd_en[c];
            exp_e[c] = 1'b0;
            if (rd_en[c]) begin
                cp = int'(CP[c*AW +: AW]);
                if (cp >= count_m) begin
                    exp_e[c] = 1'b1;
                    exp_d[c] = '0;
                end else begin
                    exp_d[c] = mem_m[cp];
`ifdef AGU_CTX_RELOAD_EN
                    if (rl_hit && int'(rl_addr) == cp) exp_d[c] = rl_data;
`endif
                end
            end
        end
`ifdef AGU_CTX_RELOAD_EN
        if (rl_hit) mem_m[rl_addr] = rl_data;
`endif
        if (clear) count_m = 0;
        else if (ld_valid && exp_ready) begin
            mem_m[count_m] = ld_data;
            count_m++;
        end
        run_m = start;
        @(posedge CLK);
        #1;
        check_outputs();
    endtask

    task automatic load_words(input int n, input logic [WIDTH-1:0] base);
        for (int i = 0; i < n; i++) begin
            ld_valid = 1'b1;
            ld_data  = base + WIDTH'(i);
            step();
        end
        ld_valid = 1'b0;
    endtask

    task automatic rd2(input logic [1:0] en, input int cp0, input int cp1);
        rd_en = en;
        CP[0 +: AW]  = AW'(cp0);
        CP[AW +: AW] = AW'(cp1);
        step();
        rd_en = '0;
    endtask

    int rnd_cp;

    initial begin
        start = 1'b0;
        quiet();
        RST_N = 1'b0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_err", 64'(rd_err), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        check("rst_ld_ready", 64'(ld_ready), 64'd1);
        RST_N = 1'b1;

        // fill to DEPTH, then one extra word must be ignored
        load_words(DEPTH, 29'h100);
        check("full_flag", 64'(full), 64'd1);
        check("full_ready", 64'(ld_ready), 64'd0);
        ld_valid = 1'b1; ld_data = 29'h1FFFFFFF;
        step();
        ld_valid = 1'b0;
        check("sat_count", 64'(count), 64'(DEPTH));
        start = 1'b1; step();
        rd2(2'b11, 63, 0);
        rd2(2'b11, 17, 17);

        // three words, two channels, then an out-of-range pointer
        start = 1'b0; clear = 1'b1; step(); clear = 1'b0;
        load_words(3, 29'h100);
        start = 1'b1; step();
        rd2(2'b11, 2, 0);
        check("tp_rd_data0", 64'(rd_data[0 +: WIDTH]), 64'h102);
        check("tp_rd_data1", 64'(rd_data[WIDTH +: WIDTH]), 64'h100);
        rd2(2'b01, 5, 0);
        check("tp_oor_err0", 64'(rd_err[0]), 64'd1);
        rd2(2'b10, 0, 3);
        step();

        // clear together with ld_valid drops the word; next load lands at 0
        start = 1'b0; step();
        clear = 1'b1; step(); clear = 1'b0;
        load_words(10, 29'h200);
        clear = 1'b1; ld_valid = 1'b1; ld_data = 29'h1234; step();
        clear = 1'b0;
        load_words(1, 29'h55);
        start = 1'b1; step();
        rd2(2'b01, 0, 0);
        rd2(2'b11, 1, 0);

`ifdef AGU_CTX_RELOAD_EN
        clear = 1'b1; start = 1'b0; step(); clear = 1'b0;
        load_words(4, 29'h300);
        start = 1'b1; step();
        rl_valid = 1'b1; rl_addr = 6'd1; rl_data = 29'hABC;
        rd2(2'b01, 1, 0);
        check("rl_fwd", 64'(rd_data[0 +: WIDTH]), 64'hABC);
        rl_addr = 6'd7; rl_data = 29'h777;
        rd2(2'b11, 1, 7);
        rl_valid = 1'b0;
        rd2(2'b11, 1, 3);
`endif

        // randomized traffic
        quiet();
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 19) == 0) start = ~start;
            clear    = ($urandom_range(0, 59) == 0);
            ld_valid = ($urandom_range(0, 3) != 0);
            ld_data  = WIDTH'($urandom);
            rd_en    = NCH'($urandom_range(0, 3));
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, 1) == 0 || count_m == 0) rnd_cp = $urandom_range(0, 63);
                else rnd_cp = $urandom_range(0, count_m - 1);
                CP[c*AW +: AW] = AW'(rnd_cp);
            end
`ifdef AGU_CTX_RELOAD_EN
            rl_valid = ($urandom_range(0, 2) == 0);
            rl_addr  = AW'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) rl_addr = CP[0 +: AW];
            rl_data  = WIDTH'($urandom);
`endif
            step();
        end

        // asynchronous reset in the middle of a run with reads pending
        quiet();
        start = 1'b1; step();
        rd2(2'b11, 0, 1);
        rd_en = 2'b11;
        step();
        #2;
        RST_N = 1'b0;
        #1;
        model_reset();
        check("arst_rd_valid", 64'(rd_valid), 64'd0);
        check("arst_count", 64'(count), 64'd0);
        check("arst_rd_data", 64'(rd_data), 64'd0);
        quiet();
        start = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("arst_ld_ready", 64'(ld_ready), 64'd1);
        load_words(2, 29'h400);
        start = 1'b1; step();
        rd2(2'b11, 1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
